// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32 core: load-use bubbles,
// multi-cycle EX freezes and branch flushes. Define HAZARD_STALL_CNT_EN for the stall counter.
module hazard_ctrl #(
  parameter int LD_BUBBLES = 1,
  parameter int LAT_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       id_rs3_addr_i,
  input  logic             id_rs1_use_I_i,
  input  logic             id_rs2_use_I_i,
  input  logic             id_rs1_use_F_i,
  input  logic             id_rs2_use_F_i,
  input  logic             id_rs3_use_F_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_I_i,
  input  logic             ex_rd_wren_F_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_mc_start_i,
  input  logic [LAT_W-1:0] ex_mc_lat_i,
  input  logic             ex_br_taken_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The down-counter serves both the 3-bit bubble count and the latency count.
  localparam int CW = (LAT_W > 3) ? LAT_W : 3;
  localparam logic [CW-1:0] LD_RELOAD = CW'((LD_BUBBLES > 1) ? (LD_BUBBLES - 2) : 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    MCOP  = 2'd2
  } state_e;

  state_e        state_r;
  state_e        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  logic rd_nz_s;
  logic int_hit_s;
  logic flt_hit_s;
  logic ld_haz_s;
  logic mc_go_s;

  logic pc_en_s;
  logic if_id_en_s;
  logic id_ex_en_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic ex_mem_flush_s;

  // x0 / f0 never create a dependency, matching the forwarding policy.
  assign rd_nz_s   = (ex_rd_addr_i != 5'd0);
  assign int_hit_s = (id_rs1_use_I_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_use_I_i && (id_rs2_addr_i == ex_rd_addr_i));
  assign flt_hit_s = (id_rs1_use_F_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_use_F_i && (id_rs2_addr_i == ex_rd_addr_i)) ||
                     (id_rs3_use_F_i && (id_rs3_addr_i == ex_rd_addr_i));
  assign ld_haz_s  = ex_mem_read_i && rd_nz_s &&
                     ((ex_rd_wren_I_i && int_hit_s) || (ex_rd_wren_F_i && flt_hit_s));
  assign mc_go_s   = ex_mc_start_i && (ex_mc_lat_i >= LAT_W'(2));

  // Next-state, counter and Mealy pipeline-control decode.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    pc_en_s        = 1'b1;
    if_id_en_s     = 1'b1;
    id_ex_en_s     = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    if (!rst_ni) begin
      state_nxt_s = RUN;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (mc_go_s) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_en_s     = 1'b0;
            ex_mem_flush_s = 1'b1;
            cnt_nxt_s      = CW'(ex_mc_lat_i) - CW'(2);
            state_nxt_s    = MCOP;
          end else if (ex_br_taken_i) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (ld_haz_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
            if (LD_BUBBLES > 1) begin
              cnt_nxt_s   = LD_RELOAD;
              state_nxt_s = LDUSE;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        LDUSE: begin
          pc_en_s       = 1'b0;
          if_id_en_s    = 1'b0;
          id_ex_flush_s = 1'b1;
          if (cnt_r == '0) begin
            state_nxt_s = RUN;
          end else begin
            cnt_nxt_s = cnt_r - CW'(1);
          end
        end
        MCOP: begin
          if (cnt_r != '0) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_en_s     = 1'b0;
            ex_mem_flush_s = 1'b1;
            cnt_nxt_s      = cnt_r - CW'(1);
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Sequencer state and down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign pc_en_o        = pc_en_s;
  assign if_id_en_o     = if_id_en_s;
  assign id_ex_en_o     = id_ex_en_s;
  assign if_id_flush_o  = if_id_flush_s;
  assign id_ex_flush_o  = id_ex_flush_s;
  assign ex_mem_flush_o = ex_mem_flush_s;
  assign busy_o         = (state_r != RUN);

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= '0;
    end else if (!pc_en_s && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LD_BUBBLES=1, one with LD_BUBBLES=3,
// sharing stimulus.
module tb_hazard_ctrl;

  // Output vector order: pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, busy
  localparam logic [6:0] IDLE      = 7'b1110000;
  localparam logic [6:0] LD_RUN    = 7'b0010100;
  localparam logic [6:0] LD_BUSY   = 7'b0010101;
  localparam logic [6:0] FRZ_RUN   = 7'b0000010;
  localparam logic [6:0] FRZ_BUSY  = 7'b0000011;
  localparam logic [6:0] RELEASE   = 7'b1110001;
  localparam logic [6:0] BR_FLUSH  = 7'b1111100;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1, rs2, rs3, rd;
  logic        use_i1, use_i2, use_f1, use_f2, use_f3;
  logic        wren_i, wren_f, mem_read, mc_start, br_taken;
  logic [4:0]  mc_lat;
  logic        pc1, ifid1, idex1, ifidf1, idexf1, exmf1, busy1;
  logic        pc3, ifid3, idex3, ifidf3, idexf3, exmf3, busy3;
  logic [31:0] stall_cnt1, stall_cnt3;
  logic [6:0]  obs1, obs3;
  logic [31:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign obs1 = {pc1, ifid1, idex1, ifidf1, idexf1, exmf1, busy1};
  assign obs3 = {pc3, ifid3, idex3, ifidf3, idexf3, exmf3, busy3};

  hazard_ctrl #(.LD_BUBBLES(1), .LAT_W(5), .CNT_W(32)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs3_addr_i(rs3),
    .id_rs1_use_I_i(use_i1), .id_rs2_use_I_i(use_i2),
    .id_rs1_use_F_i(use_f1), .id_rs2_use_F_i(use_f2), .id_rs3_use_F_i(use_f3),
    .ex_rd_addr_i(rd), .ex_rd_wren_I_i(wren_i), .ex_rd_wren_F_i(wren_f),
    .ex_mem_read_i(mem_read), .ex_mc_start_i(mc_start), .ex_mc_lat_i(mc_lat),
    .ex_br_taken_i(br_taken),
    .pc_en_o(pc1), .if_id_en_o(ifid1), .id_ex_en_o(idex1),
    .if_id_flush_o(ifidf1), .id_ex_flush_o(idexf1), .ex_mem_flush_o(exmf1),
    .busy_o(busy1), .stall_cnt_o(stall_cnt1)
  );

  hazard_ctrl #(.LD_BUBBLES(3), .LAT_W(5), .CNT_W(32)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs3_addr_i(rs3),
    .id_rs1_use_I_i(use_i1), .id_rs2_use_I_i(use_i2),
    .id_rs1_use_F_i(use_f1), .id_rs2_use_F_i(use_f2), .id_rs3_use_F_i(use_f3),
    .ex_rd_addr_i(rd), .ex_rd_wren_I_i(wren_i), .ex_rd_wren_F_i(wren_f),
    .ex_mem_read_i(mem_read), .ex_mc_start_i(mc_start), .ex_mc_lat_i(mc_lat),
    .ex_br_taken_i(br_taken),
    .pc_en_o(pc3), .if_id_en_o(ifid3), .id_ex_en_o(idex3),
    .if_id_flush_o(ifidf3), .id_ex_flush_o(idexf3), .ex_mem_flush_o(exmf3),
    .busy_o(busy3), .stall_cnt_o(stall_cnt3)
  );

  task automatic drive_idle();
    rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0; rd = 5'd0;
    use_i1 = 1'b0; use_i2 = 1'b0; use_f1 = 1'b0; use_f2 = 1'b0; use_f3 = 1'b0;
    wren_i = 1'b0; wren_f = 1'b0; mem_read = 1'b0;
    mc_start = 1'b0; mc_lat = 5'd0; br_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic int_load_use();
    mem_read = 1'b1; wren_i = 1'b1; rd = 5'd5; rs1 = 5'd5; use_i1 = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    int_load_use();
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL reset_outs1 got %b want %b", obs1, IDLE); end
    checks++;
    if (obs3 !== IDLE) begin errors++; $display("FAIL reset_outs3 got %b want %b", obs3, IDLE); end
    checks++;
    if (stall_cnt1 !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt1); end
    checks++;
    drive_idle();
    #3 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_ld_int();
    int_load_use();
    #3;
    if (obs1 !== LD_RUN) begin errors++; $display("FAIL ld_int_stall1 got %b want %b", obs1, LD_RUN); end
    checks++;
    if (obs3 !== LD_RUN) begin errors++; $display("FAIL ld_int_stall3 got %b want %b", obs3, LD_RUN); end
    checks++;
    tick();
    drive_idle();
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL ld_int_after1 got %b want %b", obs1, IDLE); end
    checks++;
    for (int i = 0; i < 2; i++) begin
      if (obs3 !== LD_BUSY) begin errors++; $display("FAIL ld_int_bubble3 c%0d got %b want %b", i, obs3, LD_BUSY); end
      checks++;
      tick();
      #3;
    end
    if (obs3 !== IDLE) begin errors++; $display("FAIL ld_int_done3 got %b want %b", obs3, IDLE); end
    checks++;
    // Unused operand must not trigger a stall.
    int_load_use();
    use_i1 = 1'b0;
    #1;
    if (obs1 !== IDLE) begin errors++; $display("FAIL ld_unused_rs got %b want %b", obs1, IDLE); end
    checks++;
    drive_idle();
    tick();
  endtask

  task automatic test_ld_float();
    logic [6:0] exp3;
    mem_read = 1'b1; wren_f = 1'b1; rd = 5'd7;
    rs1 = 5'd1; rs2 = 5'd2; rs3 = 5'd7; use_f1 = 1'b1; use_f2 = 1'b1; use_f3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) drive_idle();
      #3;
      exp3 = (i == 0) ? LD_RUN : ((i == 3) ? IDLE : LD_BUSY);
      if (obs3 !== exp3) begin errors++; $display("FAIL ld_flt3 c%0d got %b want %b", i, obs3, exp3); end
      checks++;
      tick();
    end
    mem_read = 1'b1; wren_i = 1'b1; rd = 5'd0; rs1 = 5'd0; use_i1 = 1'b1;
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL ld_x0_int got %b want %b", obs1, IDLE); end
    checks++;
    wren_i = 1'b0; wren_f = 1'b1; use_i1 = 1'b0; use_f1 = 1'b1;
    #1;
    if (obs3 !== IDLE) begin errors++; $display("FAIL ld_f0 got %b want %b", obs3, IDLE); end
    checks++;
    drive_idle();
    tick();
  endtask

  task automatic test_multicycle();
    logic [6:0] exp1;
    for (int i = 0; i < 10; i++) begin
      mc_start = 1'b1; mc_lat = 5'd10;
      br_taken = (i == 5) ? 1'b1 : 1'b0;
      int_load_use();
      #3;
      exp1 = (i == 0) ? FRZ_RUN : ((i < 9) ? FRZ_BUSY : RELEASE);
      if (obs1 !== exp1) begin errors++; $display("FAIL mc10 c%0d got %b want %b", i, obs1, exp1); end
      checks++;
      tick();
    end
    drive_idle();
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL mc10_after got %b want %b", obs1, IDLE); end
    checks++;
    tick();
    mc_start = 1'b1; mc_lat = 5'd1;
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL mc_lat1 got %b want %b", obs1, IDLE); end
    checks++;
    tick();
    mc_lat = 5'd2;
    #3;
    if (obs1 !== FRZ_RUN) begin errors++; $display("FAIL mc_lat2_frz got %b want %b", obs1, FRZ_RUN); end
    checks++;
    tick();
    #3;
    if (obs1 !== RELEASE) begin errors++; $display("FAIL mc_lat2_rel got %b want %b", obs1, RELEASE); end
    checks++;
    tick();
    drive_idle();
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL mc_lat2_after got %b want %b", obs1, IDLE); end
    checks++;
    tick();
  endtask

  task automatic test_branch_vs_ld();
    int_load_use();
    br_taken = 1'b1;
    #3;
    if (obs1 !== BR_FLUSH) begin errors++; $display("FAIL br_ld1 got %b want %b", obs1, BR_FLUSH); end
    checks++;
    if (obs3 !== BR_FLUSH) begin errors++; $display("FAIL br_ld3 got %b want %b", obs3, BR_FLUSH); end
    checks++;
    tick();
    drive_idle();
    #3;
    if (obs3 !== IDLE) begin errors++; $display("FAIL br_after3 got %b want %b", obs3, IDLE); end
    checks++;
    tick();
  endtask

  task automatic test_counter();
    rst_ni = 1'b0;
    #3 rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      mc_start = 1'b1; mc_lat = 5'd4;
      tick();
    end
    drive_idle();
    int_load_use();
    #3;
    exp_cnt = CNT_ON ? 32'd3 : 32'd0;
    if (stall_cnt1 !== exp_cnt) begin errors++; $display("FAIL cnt_mc got %0d want %0d", stall_cnt1, exp_cnt); end
    checks++;
    tick();
    drive_idle();
    #3;
    exp_cnt = CNT_ON ? 32'd4 : 32'd0;
    if (stall_cnt1 !== exp_cnt) begin errors++; $display("FAIL cnt_total got %0d want %0d", stall_cnt1, exp_cnt); end
    checks++;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      mc_start = 1'b1; mc_lat = 5'd10;
      tick();
    end
    #3;
    if (obs1 !== FRZ_BUSY) begin errors++; $display("FAIL rmid_pre got %b want %b", obs1, FRZ_BUSY); end
    checks++;
    exp_cnt = CNT_ON ? 32'd8 : 32'd0;
    if (stall_cnt1 !== exp_cnt) begin errors++; $display("FAIL rmid_cnt_pre got %0d want %0d", stall_cnt1, exp_cnt); end
    checks++;
    rst_ni = 1'b0;
    #1;
    if (obs1 !== IDLE) begin errors++; $display("FAIL rmid_outs got %b want %b", obs1, IDLE); end
    checks++;
    if (stall_cnt1 !== 32'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", stall_cnt1); end
    checks++;
    drive_idle();
    #1 rst_ni = 1'b1;
    tick();
    #3;
    if (obs1 !== IDLE) begin errors++; $display("FAIL rmid_after got %b want %b", obs1, IDLE); end
    checks++;
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive_idle();
    tick();
    test_reset();
    test_ld_int();
    test_ld_float();
    test_multicycle();
    test_branch_vs_ld();
    test_counter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage RV32 integer/float core. It sits beside the forwarding network and handles the hazards forwarding cannot cover:
- load-use dependencies, resolved by inserting a configurable number of bubbles;
- multi-cycle EX operations (FDIV/FSQRT/DIV), resolved by freezing the front end for the operation's latency;
- taken-branch redirects from EX, resolved by flushing the wrong-path instructions.

It drives the PC enable and the per-stage pipeline-register enable and flush signals.

## Interface
Parameters:
- LD_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
- LAT_W, 5, width of multi-cycle latency field
- CNT_W, 32, width of stall performance counter

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- id_rs1_addr_i, id_rs2_addr_i, id_rs3_addr_i  in  5 each  source addresses of instruction in ID
- id_rs1_use_I_i, id_rs2_use_I_i  in  1 each  integer operand actually read
- id_rs1_use_F_i, id_rs2_use_F_i, id_rs3_use_F_i  in  1 each  float operand actually read
- ex_rd_addr_i  in  5  destination of instruction in EX
- ex_rd_wren_I_i, ex_rd_wren_F_i  in  1 each  EX writes integer / float file
- ex_mem_read_i  in  1  EX instruction is a load
- ex_mc_start_i  in  1  EX instruction is multi-cycle (held while it occupies EX)
- ex_mc_lat_i  in  LAT_W  total EX cycles of that operation
- ex_br_taken_i  in  1  branch/jump redirect resolved in EX
- pc_en_o, if_id_en_o, id_ex_en_o  out  1 each  register enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  insert bubble
- busy_o  out  1  state != RUN
- stall_cnt_o  out  CNT_W  stall-cycle counter

## Operation
- States: RUN, LDUSE, MCOP. Down-counter cnt is 3 bits in LDUSE and LAT_W bits in MCOP.
- Idle outputs: all enables = 1, all flushes = 0. These are also the output values while rst_ni is low.
- Hazard matching:
  - Integer hazard: ex_mem_read_i & ex_rd_wren_I_i & ex_rd_addr_i != 0 & ex_rd_addr_i matches any used integer rs.
  - Float hazard: same condition with ex_rd_wren_F_i against used float rs1/rs2/rs3.
  - Address 0 is excluded for both files, consistent with the forwarding policy.
- RUN, priority order (highest first):
  1. **Multi-cycle start.** Condition: ex_mc_start_i & ex_mc_lat_i >= 2.
     - Outputs: pc_en = if_id_en = id_ex_en = 0, ex_mem_flush = 1.
     - Load cnt = lat - 2, go to MCOP.
     - lat of 0 or 1: no action.
  2. **Branch taken.** if_id_flush = id_ex_flush = 1; PC loads the redirect. Any coincident load-use hazard is discarded.
  3. **Load-use hazard.** pc_en = if_id_en = 0, id_ex_flush = 1.
     - If LD_BUBBLES > 1: load cnt = LD_BUBBLES - 2, go to LDUSE.
     - Otherwise stay in RUN.
- LDUSE:
  - Same stall outputs as a load-use hazard.
  - If cnt == 0, go to RUN; else cnt--.
  - ex_* inputs are ignored in this state.
- MCOP:
  - If cnt != 0: freeze outputs as at multi-cycle start, cnt--.
  - If cnt == 0: release cycle with idle outputs, go to RUN.
  - ex_mc_start_i, ex_br_taken_i and hazard inputs are ignored.
- Reset asserted mid-stall: immediately go to RUN with cnt = 0, stall_cnt_o = 0, and outputs at idle values.

## Timing
- Outputs are Mealy: combinational from state and inputs in the detection cycle, with zero latency.
- A load-use hazard detected in cycle t stalls cycles t .. t+LD_BUBBLES-1, giving exactly LD_BUBBLES bubbles.
- A multi-cycle op entering EX at cycle t with lat L:
  - Freeze for cycles t .. t+L-2.
  - Release at t+L-1; the op leaves EX at the end of t+L-1.
- State and counter update on the rising edge of clk_i.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - stall_cnt_o increments by 1 each cycle in which pc_en_o = 0.
  - Saturates at all-ones.
  - Clears on reset.
- Not defined: stall_cnt_o is tied to 0 and no counter flops are synthesized.

## Test plan
- **Load-use, integer:** EX load with rd = x5, ID reads rs1 = x5 (use_I), LD_BUBBLES = 1 -> one cycle with pc_en = 0 and id_ex_flush = 1; next cycle idle.
- **Load-use, float, LD_BUBBLES = 3:** EX FLW with rd = f7, ID rs3 = f7 (use_F) -> 3 stall cycles, busy_o high for 2 of them; rd = x0 with wren_I gives no stall.
- **Multi-cycle:** ex_mc_start with lat = 10 held 10 cycles -> 9 freeze cycles with ex_mem_flush = 1, release on the 10th; no retrigger.
- **Branch vs load-use:** both conditions true in the same cycle -> if_id_flush = id_ex_flush = 1, pc_en = 1, no stall.
- **Reset mid-op:** rst_ni low during MCOP with cnt = 5 -> outputs idle immediately, busy_o = 0, stall_cnt_o = 0.
- **Counter:** with HAZARD_STALL_CNT_EN, one lat = 4 op plus one load-use (LD_BUBBLES = 1) -> stall_cnt_o = 4; without the macro, stall_cnt_o stays 0.
